// File: rtl/data_memory_responder_pkg.sv
// Shared constants for the CPU data-memory responder: address map,
// MMIO register offsets and timer control/status bit positions.
package data_memory_responder_pkg;

    localparam int          ADDR_W    = 10;
    localparam logic [9:0]  MMIO_BASE = 10'h3F0;
    localparam int          RAM_WORDS = 1008;

    // Word offsets inside the 16-word MMIO page
    typedef enum logic [3:0] {
        OFF_CYCLE_LO  = 4'd0,
        OFF_CYCLE_HI  = 4'd1,
        OFF_TIMER_CMP = 4'd2,
        OFF_TIMER_CTL = 4'd3,
        OFF_TIMER_CNT = 4'd4,
        OFF_TIMER_STS = 4'd5,
        OFF_SCRATCH   = 4'd6
    } mmio_off_e;

    // TIMER_CTRL bit positions
    localparam int CTRL_EN     = 0;
    localparam int CTRL_RELOAD = 1;
    localparam int CTRL_IRQ_EN = 2;

    // TIMER_STATUS bit position
    localparam int STS_MATCH = 0;

endpackage

// File: rtl/data_memory_responder_mmio_timer.sv
// Compare timer with auto-reload / one-shot modes, sticky match flag and
// level interrupt. Register reads are combinational on the offset.
module data_memory_responder_mmio_timer
    import data_memory_responder_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        wr_en_i,   // write strobe, already qualified by MMIO select
    input  mmio_off_e   off_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        irq_o
);

    logic [31:0] cmp_q, cmp_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] cnt_q, cnt_d;
    logic        flag_q, flag_d;
    logic        match;

    // Timer advance first, then CPU writes override it (write wins over
    // count/reload and over the one-shot enable clear; match wins over W1C)
    always_comb begin
        cmp_d  = cmp_q;
        ctrl_d = ctrl_q;
        cnt_d  = cnt_q;
        flag_d = flag_q;
        match  = ctrl_q[CTRL_EN] && (cnt_q == cmp_q);

        if (ctrl_q[CTRL_EN]) begin
            if (match) begin
                flag_d = 1'b1;
                if (ctrl_q[CTRL_RELOAD]) begin
                    cnt_d = 32'd0;
                end else begin
                    ctrl_d[CTRL_EN] = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end

        if (wr_en_i) begin
            case (off_i)
                OFF_TIMER_CMP: cmp_d  = wdata_i;
                OFF_TIMER_CTL: ctrl_d = wdata_i[2:0];
                OFF_TIMER_CNT: cnt_d  = wdata_i;
                OFF_TIMER_STS: if (wdata_i[STS_MATCH] && !match) flag_d = 1'b0;
                default: ;
            endcase
        end
    end

    // Timer state registers, cleared asynchronously
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cmp_q  <= '0;
            ctrl_q <= '0;
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            cmp_q  <= cmp_d;
            ctrl_q <= ctrl_d;
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
        end
    end

    // Register read mux; offsets owned by the top return 0 here
    always_comb begin
        rdata_o = 32'd0;
        case (off_i)
            OFF_TIMER_CMP: rdata_o = cmp_q;
            OFF_TIMER_CTL: rdata_o = {29'd0, ctrl_q};
            OFF_TIMER_CNT: rdata_o = cnt_q;
            OFF_TIMER_STS: rdata_o = {31'd0, flag_q};
            default:       rdata_o = 32'd0;
        endcase
    end

    assign irq_o = flag_q & ctrl_q[CTRL_IRQ_EN];

endmodule

// File: rtl/data_memory_responder.sv
// Responder for the CPU data-memory port: word RAM below MMIO_BASE, MMIO
// page above it (64-bit cycle counter with HI snapshot, timer, scratch).
// Read data is combinational; stores land on the rising edge.
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int                ADDR_W    = data_memory_responder_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] MMIO_BASE = data_memory_responder_pkg::MMIO_BASE,
    parameter int                RAM_WORDS = data_memory_responder_pkg::RAM_WORDS
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] RAM_ADDR,
    input  logic [31:0]       RAM_WRITE_DATA,
    input  logic              RAM_WRITE_ENABLE,
    output logic [31:0]       RAM_READ_DATA,
    output logic              TIMER_IRQ
);

    logic [31:0] mem [RAM_WORDS];

    logic        is_mmio;
    mmio_off_e   off;
    logic        mmio_we;

    logic [63:0] cycle_q, cycle_d;
    logic [31:0] snap_q, snap_d;
    logic [31:0] scratch_q, scratch_d;
    logic [31:0] timer_rdata;

    // Low four bits of (addr - base) equal the difference of the low bits
    assign is_mmio = (RAM_ADDR >= MMIO_BASE);
    assign off     = mmio_off_e'(RAM_ADDR[3:0] - MMIO_BASE[3:0]);
    assign mmio_we = RAM_WRITE_ENABLE && is_mmio;

    // RAM store; not reset, and blocked while reset is held
    always_ff @(posedge CLK) begin
        if (RST_N && RAM_WRITE_ENABLE && !is_mmio) begin
            mem[RAM_ADDR] <= RAM_WRITE_DATA;
        end
    end

    // Cycle count, HI snapshot on every non-store LO select, scratch write
    always_comb begin
        cycle_d   = cycle_q + 64'd1;
        snap_d    = snap_q;
        scratch_d = scratch_q;
        if (is_mmio && off == OFF_CYCLE_LO && !RAM_WRITE_ENABLE) begin
            snap_d = cycle_q[63:32];
        end
        if (mmio_we && off == OFF_SCRATCH) begin
            scratch_d = RAM_WRITE_DATA;
        end
    end

    // Top-level MMIO registers, cleared asynchronously
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cycle_q   <= '0;
            snap_q    <= '0;
            scratch_q <= '0;
        end else begin
            cycle_q   <= cycle_d;
            snap_q    <= snap_d;
            scratch_q <= scratch_d;
        end
    end

    data_memory_responder_mmio_timer u_timer (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .wr_en_i (mmio_we),
        .off_i   (off),
        .wdata_i (RAM_WRITE_DATA),
        .rdata_o (timer_rdata),
        .irq_o   (TIMER_IRQ)
    );

    // Combinational read: old RAM contents on a same-cycle store
    always_comb begin
        RAM_READ_DATA = 32'd0;
        if (!is_mmio) begin
            RAM_READ_DATA = mem[RAM_ADDR];
        end else begin
            case (off)
                OFF_CYCLE_LO: RAM_READ_DATA = cycle_q[31:0];
                OFF_CYCLE_HI: RAM_READ_DATA = snap_q;
                OFF_SCRATCH:  RAM_READ_DATA = scratch_q;
                default:      RAM_READ_DATA = timer_rdata;
            endcase
        end
    end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Responder end of the CPU data-memory port.
- Takes the CPU's word address, write data and write enable. Returns read data in the same cycle the address is presented; the CPU samples it at the end of its memory stage.
- Decodes the 10-bit word address space into two regions:
  - a word RAM;
  - a small MMIO page holding a 64-bit cycle counter, a compare timer with interrupt, and a scratch register.
- Sits beside the CPU at top level, opposite the CPU's RAM_ADDR / RAM_WRITE_DATA / RAM_WRITE_ENABLE outputs.

Parameters:
- ADDR_W, 10, word-address width (matches the CPU's RAM_ADDR).
- MMIO_BASE, 10'h3F0, first word address of the 16-word MMIO page.
- RAM_WORDS, 1008, RAM depth; must equal MMIO_BASE.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- RAM_ADDR  in  ADDR_W  word address from CPU.
- RAM_WRITE_DATA  in  32  store data from CPU.
- RAM_WRITE_ENABLE  in  1  store strobe; high for one cycle per store.
- RAM_READ_DATA  out  32  combinational read data for RAM_ADDR.
- TIMER_IRQ  out  1  level interrupt = MATCH_FLAG & CTRL.irq_en.

Behaviour:
- Reset: one clock (CLK); reset is asynchronous and active-low (RST_N). Asserting RST_N=0 clears the following to 0, immediately and regardless of CLK:
  - CYCLE (64b), CYCLE_HI_SNAP, TIMER_CMP, TIMER_CTRL, TIMER_CNT, MATCH_FLAG, SCRATCH;
  - TIMER_IRQ.
- RAM contents are not reset.
- Reset mid-store: the store is lost. RAM write is not guaranteed during reset; writes are gated by RST_N.
- Read timing:
  - RAM_READ_DATA is a purely combinational function of RAM_ADDR and current state.
  - A store and a read to the same address in the same cycle return the OLD value (read-before-write).
  - The new value is visible from the next cycle.
- Writes take effect at the rising CLK edge when RAM_WRITE_ENABLE=1.
- Address decode:
  - RAM_ADDR < MMIO_BASE selects RAM.
  - Otherwise the MMIO offset is RAM_ADDR - MMIO_BASE (0..15).
- MMIO map (offset, name, access):
  - 0 CYCLE_LO, RO: low 32 bits of CYCLE. Any cycle with offset 0 selected and WE=0 latches CYCLE[63:32] into CYCLE_HI_SNAP at that edge.
  - 1 CYCLE_HI, RO: returns CYCLE_HI_SNAP, giving a torn-free 64-bit read as LO then HI.
  - 2 TIMER_CMP, RW.
  - 3 TIMER_CTRL, RW bits[2:0] = {irq_en, auto_reload, enable}; upper bits read 0.
  - 4 TIMER_CNT, RW.
  - 5 TIMER_STATUS: bit0 = MATCH_FLAG; write 1 to bit0 clears it; other bits read 0.
  - 6 SCRATCH, RW.
  - 7..15: read 0; writes ignored.
- Writes to RO offsets are ignored.
- CYCLE:
  - Increments by 1 every cycle out of reset; wraps 2^64-1 -> 0.
  - Not writable.
- Timer, evaluated each edge with enable=1:
  - If TIMER_CNT == TIMER_CMP: MATCH_FLAG <= 1. Then TIMER_CNT <= 0 if auto_reload; otherwise enable <= 0 (one-shot) and TIMER_CNT holds.
  - Else TIMER_CNT <= TIMER_CNT + 1, wrapping at 2^32.
  - CMP=0 with auto_reload gives a match every cycle.
- Simultaneous events:
  - A CPU write to TIMER_CNT beats increment/reload.
  - A CPU write to TIMER_CTRL beats the one-shot auto-clear of enable.
  - A match setting MATCH_FLAG beats a same-cycle W1C clear; the flag stays 1.
  - A write to TIMER_CMP is used from the next cycle.
- The CPU drives RAM_ADDR every cycle, including for non-memory instructions, so spurious CYCLE_LO selects refresh the snapshot. This is acceptable; software reads LO immediately before HI.

Decomposition:
- Shared package: MMIO_BASE and the offset constants (CYCLE_LO..SCRATCH), TIMER_CTRL bit indices, and the STATUS bit index.
- One sub-module, mmio_timer: TIMER_CMP/CTRL/CNT/MATCH_FLAG and the IRQ logic, with a write-strobe/offset/data input and a read-data output.
- The RAM array, decode, CYCLE and snapshot stay in the top.

Test Plan:
- RAM store/load: write 32'hDEADBEEF to addr 5 while reading addr 5 in the same cycle -> old value returned; next cycle -> 32'hDEADBEEF. Addr 1007 round-trips 32'h12345678.
- Reset: drive RST_N=0 mid-run with no CLK edge -> CYCLE, all MMIO registers and TIMER_IRQ read 0 immediately; after release, CYCLE_LO reads 1 on the first edge.
- 64-bit read: force CYCLE to 64'h0000_0000_FFFF_FFFE, read LO then HI -> LO=32'hFFFF_FFFE, HI=0. Read LO one cycle later -> 32'hFFFF_FFFF; two cycles later LO=0 and HI=1.
- Auto-reload timer:
  - Setup: CMP=3, CTRL=3'b111.
  - Expect CNT sequence 0,1,2,3,0.
  - MATCH_FLAG and TIMER_IRQ rise on the edge after CNT=3.
  - W1C to STATUS clears IRQ; the next match re-asserts it.
- One-shot and priority:
  - Setup: CMP=2, CTRL=3'b001.
  - Expect enable cleared after the match and CNT held at 2.
  - A W1C in the same cycle as a match leaves MATCH_FLAG=1.
- Unmapped/RO: write 32'hFFFF_FFFF to offsets 0, 1 and 9 -> no state change; offsets 7..15 read 0; SCRATCH round-trips 32'hA5A5_5A5A.
